// File: rtl/keypad_pkg.sv
// Shared key codes, press FSM states and bit-vector helpers for the keypad front-end.
package keypad_pkg;

  // Key code = row*4 + col.
  localparam logic [3:0] KEY_1     = 4'h0;
  localparam logic [3:0] KEY_2     = 4'h1;
  localparam logic [3:0] KEY_3     = 4'h2;
  localparam logic [3:0] KEY_START = 4'h3;
  localparam logic [3:0] KEY_4     = 4'h4;
  localparam logic [3:0] KEY_5     = 4'h5;
  localparam logic [3:0] KEY_6     = 4'h6;
  localparam logic [3:0] KEY_B     = 4'h7;
  localparam logic [3:0] KEY_7     = 4'h8;
  localparam logic [3:0] KEY_8     = 4'h9;
  localparam logic [3:0] KEY_9     = 4'hA;
  localparam logic [3:0] KEY_C     = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_0     = 4'hD;
  localparam logic [3:0] KEY_OK    = 4'hE;
  localparam logic [3:0] KEY_D     = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } press_state_e;

  function automatic logic popcount_is_one(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [3:0] onehot_to_code(input logic [15:0] v);
    logic [3:0] code;
    code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer: accepts a 16-bit key snapshot once it has repeated
// DEBOUNCE_FRAMES times in a row.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] frame,
  input  logic        frame_done,
  output logic [15:0] deb,
  output logic        deb_upd
);

  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  logic [15:0]   prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   deb_q, deb_d;
  logic          upd_q, upd_d;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    upd_d  = 1'b0;
    if (frame_done) begin
      prev_d = frame;
      if (frame == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == CNT_MAX) begin
        deb_d = frame;
        upd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      upd_q  <= upd_d;
    end
  end

  assign deb     = deb_q;
  assign deb_upd = upd_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with whole-frame debounce and one-pulse-per-press
// outputs for the password-lock FSM.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       in5,
  output logic       in6,
  output logic       in7,
  output logic       in8,
  output logic       in9,
  output logic       in0,
  output logic       ok,
  output logic       clr,
  output logic       start,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_sync_q, col_sync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [15:0]   frame_q, frame_d;
  logic          frame_done;

  press_state_e  state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  logic [15:0]   deb;
  logic          deb_upd;

  // Synchronizer and row scanner.
  always_comb begin
    col_meta_d = col_n;
    col_sync_d = col_meta_q;
    dwell_d    = dwell_q + DW'(1);
    row_d      = row_q;
    frame_d    = frame_q;
    frame_done = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d                       = '0;
      row_d                         = row_q + 2'd1;
      frame_d[{row_q, 2'b00} +: 4]  = ~col_sync_q;
      frame_done                    = (row_q == 2'd3);
    end
  end

  // The debouncer sees the frame including the r3 sample taken this cycle.
  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .frame     (frame_d),
    .frame_done(frame_done),
    .deb       (deb),
    .deb_upd   (deb_upd)
  );

  // Press FSM: one pulse per debounced single-key press, re-armed only by a debounced release.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (deb_upd) begin
      unique case (state_q)
        IDLE: begin
          if (popcount_is_one(deb)) begin
            key_valid_d = 1'b1;
            key_code_d  = onehot_to_code(deb);
            state_d     = HELD;
          end else if (deb != '0) begin
            state_d = HELD;
          end
        end
        HELD: begin
          if (deb == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q  <= '1;
      col_sync_q  <= '1;
      dwell_q     <= '0;
      row_q       <= '0;
      frame_q     <= '0;
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_sync_q  <= col_sync_d;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

  assign in1   = key_valid_q && (key_code_q == KEY_1);
  assign in2   = key_valid_q && (key_code_q == KEY_2);
  assign in3   = key_valid_q && (key_code_q == KEY_3);
  assign in4   = key_valid_q && (key_code_q == KEY_4);
  assign in5   = key_valid_q && (key_code_q == KEY_5);
  assign in6   = key_valid_q && (key_code_q == KEY_6);
  assign in7   = key_valid_q && (key_code_q == KEY_7);
  assign in8   = key_valid_q && (key_code_q == KEY_8);
  assign in9   = key_valid_q && (key_code_q == KEY_9);
  assign in0   = key_valid_q && (key_code_q == KEY_0);
  assign ok    = key_valid_q && (key_code_q == KEY_OK);
  assign clr   = key_valid_q && (key_code_q == KEY_CLR);
  assign start = key_valid_q && (key_code_q == KEY_START);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_FRAMES=3.
module tb_keypad_scan_debounce;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        in1, in2, in3, in4, in5, in6, in7, in8, in9, in0;
  logic        ok, clr, start, key_valid;
  logic [3:0]  key_code;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] code;
    int         issue;
    int         max_lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Keypad matrix: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  keypad_scan_debounce #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6),
    .in7(in7), .in8(in8), .in9(in9), .in0(in0),
    .ok(ok), .clr(clr), .start(start),
    .key_valid(key_valid), .key_code(key_code)
  );

  // Bit order {start,clr,ok,in0,in9..in1}.
  function automatic logic [12:0] exp_pulses(input logic [3:0] code);
    case (code)
      4'h0: return 13'h0001;
      4'h1: return 13'h0002;
      4'h2: return 13'h0004;
      4'h4: return 13'h0008;
      4'h5: return 13'h0010;
      4'h6: return 13'h0020;
      4'h8: return 13'h0040;
      4'h9: return 13'h0080;
      4'hA: return 13'h0100;
      4'hD: return 13'h0200;
      4'hE: return 13'h0400;
      4'hC: return 13'h0800;
      4'h3: return 13'h1000;
      default: return 13'h0000;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a key.
  initial begin
    exp_t        e;
    logic [12:0] p;
    int          lat;
    forever begin
      @(negedge clk);
      p = {start, clr, ok, in0, in9, in8, in7, in6, in5, in4, in3, in2, in1};
      if (key_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got code=%0h pulses=%b want no pulse (cycle %0d)",
                   key_code, p, cyc);
        end else begin
          e = sb_q.pop_front();
          check("key_code", int'(key_code), int'(e.code));
          check("pulse_vec", int'(p), int'(exp_pulses(e.code)));
          if (e.max_lat > 0) begin
            lat = cyc - e.issue;
            total++;
            if (lat > e.max_lat) begin
              bad++;
              $display("FAIL latency: got=%0d want<=%0d", lat, e.max_lat);
            end
          end
        end
      end else if (p != '0) begin
        total++;
        bad++;
        $display("FAIL stray_pulse: got pulses=%b want 0 without key_valid", p);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drained", sb_q.size(), 0);
  endtask

  task automatic press_key(input logic [3:0] code, input int hold_n, input int rel_n);
    keys       = '0;
    keys[code] = 1'b1;
    sb_q.push_back('{code, cyc, 84});
    hold(hold_n);
    keys = '0;
    drain(1);
    hold(rel_n);
  endtask

  task automatic check_reset_outputs();
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_pulses", int'({start, clr, ok, in0, in9, in8, in7, in6, in5, in4, in3, in2, in1}), 0);
  endtask

  initial begin
    logic [3:0] seq[6];
    int         exp_row;

    // 1: reset, row rotation, idle with no pulses.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_row = (i / 4) % 4;
      check("row_scan", int'(row_n), int'(~(4'b0001 << exp_row)) & 4'hF);
    end
    hold(500);

    // 2: clean press of '5'.
    press_key(4'h5, 200, 100);

    // 3: bouncing press then bouncing release of '5'.
    for (int i = 0; i < 20; i++) begin
      keys[5] = ~keys[5];
      hold(3);
    end
    keys[5] = 1'b1;
    sb_q.push_back('{4'h5, cyc, 84});
    hold(200);
    drain(1);
    for (int i = 0; i < 11; i++) begin
      keys[5] = ~keys[5];
      hold(3);
    end
    keys = '0;
    hold(150);

    // 4: two keys together are rejected; '#' afterwards is accepted.
    keys = '0;
    keys[0]  = 1'b1;
    keys[10] = 1'b1;
    hold(200);
    keys = '0;
    hold(100);
    press_key(4'hE, 150, 100);

    // 5: lock-entry sequence A,1,2,3,4,#.
    seq[0] = 4'h3; seq[1] = 4'h0; seq[2] = 4'h1;
    seq[3] = 4'h2; seq[4] = 4'h4; seq[5] = 4'hE;
    for (int i = 0; i < 6; i++) press_key(seq[i], 150, 100);

    // 6: reset mid-debounce of '7'; one pulse after re-debounce.
    keys    = '0;
    keys[8] = 1'b1;
    hold(30);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back('{4'h8, cyc, 84});
    hold(200);
    keys = '0;
    drain(1);
    hold(150);
    check("final_queue", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
